multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/mcu_pkg.sv | 46 ++++
 rtl/multicycle_control_unit_if.sv | 34 +++
 rtl/mcu_main_fsm.sv | 86 ++++++++
 rtl/multicycle_control_unit.sv | 123 ++++++++++++
 tb/tb_multicycle_control_unit.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mcu_pkg.sv
// Shared constants for the multicycle control unit: FSM state codes,
// opcode classes, ALU command fields, ALUControl encodings, FSM control bundle.
package mcu_pkg;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXECR  = 4'd6;
    localparam logic [3:0] S_EXECI  = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [2:0] ALUC_ADD = 3'b000;
    localparam logic [2:0] ALUC_SUB = 3'b001;
    localparam logic [2:0] ALUC_AND = 3'b010;
    localparam logic [2:0] ALUC_ORR = 3'b011;
    localparam logic [2:0] ALUC_EOR = 3'b100;

    typedef struct packed {
        logic       pcupdate;
        logic       adrsrc;
        logic       irwrite;
        logic       regw;
        logic       memw;
        logic       branch;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       aluop;
    } fsm_ctrl_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Instruction-field / control-output bundle of the multicycle control unit.
// master = instruction source + control consumer, slave = control unit side.
interface multicycle_control_unit_if #(
    parameter int ALU_CTRL_W = 2
);
    logic [3:0]            Cond;
    logic [3:0]            ALUFlags;
    logic [1:0]            Op;
    logic [5:0]            Funct;
    logic [3:0]            Rd;
    logic                  PCWrite;
    logic                  AdrSrc;
    logic                  MemWrite;
    logic                  IRWrite;
    logic                  RegWrite;
    logic [1:0]            ResultSrc;
    logic                  ALUSrcA;
    logic [1:0]            ALUSrcB;
    logic [1:0]            ImmSrc;
    logic [1:0]            RegSrc;
    logic [ALU_CTRL_W-1:0] ALUControl;

    modport master (
        output Cond, ALUFlags, Op, Funct, Rd,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
        input  ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl
    );

    modport slave (
        input  Cond, ALUFlags, Op, Funct, Rd,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
        output ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl
    );
endinterface

// File: rtl/mcu_main_fsm.sv
// Moore main FSM: ten one-cycle states, outputs the raw control bundle.
// Ports: clk, reset (sync, active-high), op, funct5 (I bit), funct0 (S/L bit), ctrl.
module mcu_main_fsm
    import mcu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic       funct5,
    input  logic       funct0,
    output fsm_ctrl_t  ctrl
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [3:0] state;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // FETCH controls are presented while reset is held, whatever state_q is.
    assign state = reset ? S_FETCH : state_q;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = funct5 ? S_EXECI : S_EXECR;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = funct0 ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECR:  state_d = S_ALUWB;
            S_EXECI:  state_d = S_ALUWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.pcupdate  = 1'b1;
                ctrl.irwrite   = 1'b1;
                ctrl.alusrca   = 1'b1;
                ctrl.alusrcb   = 2'b10;
                ctrl.resultsrc = 2'b10;
            end
            S_DECODE: begin
                ctrl.alusrca   = 1'b1;
                ctrl.alusrcb   = 2'b10;
                ctrl.resultsrc = 2'b10;
            end
            S_MEMADR: ctrl.alusrcb = 2'b01;
            S_MEMRD:  ctrl.adrsrc  = 1'b1;
            S_MEMWB: begin
                ctrl.resultsrc = 2'b01;
                ctrl.regw      = 1'b1;
            end
            S_MEMWR: begin
                ctrl.adrsrc = 1'b1;
                ctrl.memw   = 1'b1;
            end
            S_EXECR:  ctrl.aluop = 1'b1;
            S_EXECI: begin
                ctrl.alusrcb = 2'b01;
                ctrl.aluop   = 1'b1;
            end
            S_ALUWB:  ctrl.regw = 1'b1;
            S_BRANCH: begin
                ctrl.alusrcb   = 2'b01;
                ctrl.resultsrc = 2'b10;
                ctrl.branch    = 1'b1;
            end
            default:  ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle ARM-subset control unit: main FSM, ALU decode, NZCV flags, CondEx gating.
// Ports: CLK, Reset (sync, active-high), Cond/ALUFlags/Op/Funct/Rd in; datapath enables
// and selects out. Optional MCU_CMP_EN: Funct[4:1]=1010 decodes as CMP (SUB, no writeback).
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int ALU_CTRL_W = 2
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic [3:0]            Cond,
    input  logic [3:0]            ALUFlags,
    input  logic [1:0]            Op,
    input  logic [5:0]            Funct,
    input  logic [3:0]            Rd,
    output logic                  PCWrite,
    output logic                  AdrSrc,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic                  RegWrite,
    output logic [1:0]            ResultSrc,
    output logic                  ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [1:0]            ImmSrc,
    output logic [1:0]            RegSrc,
    output logic [ALU_CTRL_W-1:0] ALUControl
);

    fsm_ctrl_t  ctrl;
    logic [3:0] flags;
    logic       condex;
    logic [2:0] aluc;
    logic       addsub;
    logic       nowrite;
    logic       regw_g;

    mcu_main_fsm u_fsm (
        .clk    (CLK),
        .reset  (Reset),
        .op     (Op),
        .funct5 (Funct[5]),
        .funct0 (Funct[0]),
        .ctrl   (ctrl)
    );

    always_comb begin
        aluc   = ALUC_ADD;
        addsub = 1'b0;
        if (ctrl.aluop) begin
            case (Funct[4:1])
                CMD_ADD: addsub = 1'b1;
                CMD_SUB: begin
                    aluc   = ALUC_SUB;
                    addsub = 1'b1;
                end
                CMD_AND: aluc = ALUC_AND;
                CMD_ORR: aluc = ALUC_ORR;
                CMD_EOR: if (ALU_CTRL_W >= 3) aluc = ALUC_EOR;
`ifdef MCU_CMP_EN
                CMD_CMP: begin
                    aluc   = ALUC_SUB;
                    addsub = 1'b1;
                end
`endif
                default: aluc = ALUC_ADD;
            endcase
        end
    end

`ifdef MCU_CMP_EN
    assign nowrite = (Op == OP_DP) && (Funct[4:1] == CMD_CMP);
`else
    assign nowrite = 1'b0;
`endif

    // flags = {N, Z, C, V}
    always_comb begin
        case (Cond)
            4'b0000: condex = flags[2];
            4'b0001: condex = ~flags[2];
            4'b0010: condex = flags[1];
            4'b0011: condex = ~flags[1];
            4'b0100: condex = flags[3];
            4'b0101: condex = ~flags[3];
            4'b0110: condex = flags[0];
            4'b0111: condex = ~flags[0];
            4'b1000: condex = flags[1] & ~flags[2];
            4'b1001: condex = ~flags[1] | flags[2];
            4'b1010: condex = (flags[3] == flags[0]);
            4'b1011: condex = (flags[3] != flags[0]);
            4'b1100: condex = ~flags[2] & (flags[3] == flags[0]);
            4'b1101: condex = flags[2] | (flags[3] != flags[0]);
            4'b1110: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    // CondEx above sees the pre-update flags; the load happens at the EXEC edge.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            flags <= 4'b0000;
        end else if (ctrl.aluop && condex && Funct[0]) begin
            flags[3:2] <= ALUFlags[3:2];
            if (addsub) flags[1:0] <= ALUFlags[1:0];
        end
    end

    assign regw_g     = ctrl.regw & ~nowrite & condex;
    assign RegWrite   = regw_g;
    assign MemWrite   = ctrl.memw & condex;
    assign PCWrite    = ctrl.pcupdate
                      | (ctrl.branch & condex)
                      | (regw_g & (Rd == 4'd15));
    assign AdrSrc     = ctrl.adrsrc;
    assign IRWrite    = ctrl.irwrite;
    assign ResultSrc  = ctrl.resultsrc;
    assign ALUSrcA    = ctrl.alusrca;
    assign ALUSrcB    = ctrl.alusrcb;
    assign ImmSrc     = Op;
    assign RegSrc     = {Op == OP_MEM, Op == OP_BR};
    assign ALUControl = ALU_CTRL_W'(aluc);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Table-driven bench for multicycle_control_unit with an expected-word scoreboard.
// Optional MCU_CMP_EN selects the CMP expectations for the 1010 command.
module tb_multicycle_control_unit;

    localparam int W = 2;

    localparam int K_DPR = 0;
    localparam int K_DPI = 1;
    localparam int K_LDR = 2;
    localparam int K_STR = 3;
    localparam int K_BR  = 4;
    localparam int K_UND = 5;

    localparam int F  = 0;
    localparam int D  = 1;
    localparam int MA = 2;
    localparam int MR = 3;
    localparam int MB = 4;
    localparam int MW = 5;
    localparam int ER = 6;
    localparam int EI = 7;
    localparam int AW = 8;
    localparam int BR = 9;

    typedef struct {
        string      name;
        int         kind;
        logic [3:0] cond;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        logic [3:0] af;
        logic [1:0] alu;
        logic [4:0] pcm;
        logic [4:0] rwm;
        logic [4:0] mwm;
        logic [3:0] flags;
    } vec_t;

    logic CLK = 1'b0;
    logic Reset;
    int   n_assert = 0;
    int   n_fail = 0;
    vec_t vecs[$];
    logic [15:0] sb[$];

    multicycle_control_unit_if #(.ALU_CTRL_W(W)) bus ();

    multicycle_control_unit #(.ALU_CTRL_W(W)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Cond       (bus.Cond),
        .ALUFlags   (bus.ALUFlags),
        .Op         (bus.Op),
        .Funct      (bus.Funct),
        .Rd         (bus.Rd),
        .PCWrite    (bus.PCWrite),
        .AdrSrc     (bus.AdrSrc),
        .MemWrite   (bus.MemWrite),
        .IRWrite    (bus.IRWrite),
        .RegWrite   (bus.RegWrite),
        .ResultSrc  (bus.ResultSrc),
        .ALUSrcA    (bus.ALUSrcA),
        .ALUSrcB    (bus.ALUSrcB),
        .ImmSrc     (bus.ImmSrc),
        .RegSrc     (bus.RegSrc),
        .ALUControl (bus.ALUControl)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    function automatic int ncyc(int kind);
        case (kind)
            K_LDR:   return 5;
            K_STR:   return 4;
            K_BR:    return 3;
            K_UND:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int st_of(int kind, int i);
        int s;
        s = (i == 0) ? F : D;
        if (i == 2) begin
            case (kind)
                K_DPR:   s = ER;
                K_DPI:   s = EI;
                K_BR:    s = BR;
                default: s = MA;
            endcase
        end
        if (i == 3) s = (kind == K_LDR) ? MR : (kind == K_STR) ? MW : AW;
        if (i == 4) s = MB;
        return s;
    endfunction

    // {AdrSrc, IRWrite, ResultSrc, ALUSrcA, ALUSrcB}
    function automatic logic [6:0] base(int s);
        case (s)
            F:       return 7'b0_1_10_1_10;
            D:       return 7'b0_0_10_1_10;
            MA:      return 7'b0_0_00_0_01;
            MR:      return 7'b1_0_00_0_00;
            MB:      return 7'b0_0_01_0_00;
            MW:      return 7'b1_0_00_0_00;
            EI:      return 7'b0_0_00_0_01;
            BR:      return 7'b0_0_10_0_01;
            default: return 7'b0_0_00_0_00;
        endcase
    endfunction

    function automatic logic [15:0] exp_word(vec_t v, int i);
        int         s;
        logic [6:0] b;
        logic [1:0] alu;
        logic [1:0] rs;
        s   = st_of(v.kind, i);
        b   = base(s);
        alu = (s == ER || s == EI) ? v.alu : 2'b00;
        rs  = {v.op == 2'b01, v.op == 2'b10};
        return {v.pcm[i], b[6], v.mwm[i], b[5], v.rwm[i],
                b[4:3], b[2], b[1:0], v.op, rs, alu};
    endfunction

    function automatic logic [15:0] act_word();
        return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite,
                bus.RegWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB,
                bus.ImmSrc, bus.RegSrc, bus.ALUControl};
    endfunction

    task automatic chk(input string tag, input logic [15:0] act,
                       input logic [15:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic add(input string n, input int k, input logic [3:0] c,
                       input logic [1:0] op, input logic [5:0] f,
                       input logic [3:0] rd, input logic [3:0] af,
                       input logic [1:0] alu, input logic [4:0] pcm,
                       input logic [4:0] rwm, input logic [4:0] mwm,
                       input logic [3:0] fl);
        vec_t v;
        v.name = n; v.kind = k; v.cond = c; v.op = op; v.funct = f;
        v.rd = rd; v.af = af; v.alu = alu; v.pcm = pcm; v.rwm = rwm;
        v.mwm = mwm; v.flags = fl;
        vecs.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        bus.Cond = v.cond; bus.Op = v.op; bus.Funct = v.funct;
        bus.Rd = v.rd; bus.ALUFlags = v.af;
    endtask

    // called just after a falling edge; returns at the next falling edge
    task automatic cyc(input vec_t v, input int i);
        logic [15:0] e;
        sb.push_back(exp_word(v, i));
        #1;
        if (sb.size() == 0) begin
            chk({v.name, " sb_empty"}, 16'h0, 16'h1);
        end else begin
            e = sb.pop_front();
            chk($sformatf("%s c%0d", v.name, i), act_word(), e);
        end
        @(negedge CLK);
    endtask

    task automatic run_vec(input vec_t v);
        apply(v);
        for (int i = 0; i < ncyc(v.kind); i++) cyc(v, i);
        chk({v.name, " flags"}, {12'h0, dut.flags}, {12'h0, v.flags});
    endtask

    initial begin
        vec_t ldr;
        vec_t fv;
        // name  kind  cond op  funct  rd  af  alu pcm rwm mwm flags
        add("ADD",    K_DPR, 4'hE, 2'b00, 6'b001000, 4'd1,  4'b0000, 2'b00, 5'b00001, 5'b01000, 5'b0, 4'b0000);
        add("LDR",    K_LDR, 4'hE, 2'b01, 6'b011001, 4'd2,  4'b0000, 2'b00, 5'b00001, 5'b10000, 5'b0, 4'b0000);
        add("SUBS",   K_DPR, 4'hE, 2'b00, 6'b000101, 4'd1,  4'b0100, 2'b01, 5'b00001, 5'b01000, 5'b0, 4'b0100);
        add("BEQ",    K_BR,  4'h0, 2'b10, 6'b000000, 4'd0,  4'b0000, 2'b00, 5'b00101, 5'b00000, 5'b0, 4'b0100);
        add("BNE",    K_BR,  4'h1, 2'b10, 6'b000000, 4'd0,  4'b0000, 2'b00, 5'b00001, 5'b00000, 5'b0, 4'b0100);
        add("ANDSI",  K_DPI, 4'hE, 2'b00, 6'b100001, 4'd4,  4'b1001, 2'b10, 5'b00001, 5'b01000, 5'b0, 4'b1000);
        add("STREQ",  K_STR, 4'h0, 2'b01, 6'b011000, 4'd5,  4'b0000, 2'b00, 5'b00001, 5'b00000, 5'b0, 4'b1000);
        add("STR",    K_STR, 4'hE, 2'b01, 6'b011000, 4'd5,  4'b0000, 2'b00, 5'b00001, 5'b00000, 5'b01000, 4'b1000);
        add("ORRPC",  K_DPR, 4'hE, 2'b00, 6'b011000, 4'd15, 4'b0000, 2'b11, 5'b01001, 5'b01000, 5'b0, 4'b1000);
        add("UNDEF",  K_UND, 4'hE, 2'b11, 6'b000000, 4'd1,  4'b1111, 2'b00, 5'b00001, 5'b00000, 5'b0, 4'b1000);
`ifdef MCU_CMP_EN
        add("CMP",    K_DPR, 4'hE, 2'b00, 6'b010101, 4'd3,  4'b0110, 2'b01, 5'b00001, 5'b00000, 5'b0, 4'b0110);
`else
        add("C1010",  K_DPR, 4'hE, 2'b00, 6'b010100, 4'd3,  4'b0110, 2'b00, 5'b00001, 5'b01000, 5'b0, 4'b1000);
`endif
        add("EORW2",  K_DPR, 4'hE, 2'b00, 6'b000010, 4'd3,  4'b0000, 2'b00, 5'b00001, 5'b01000, 5'b0, 4'b1000);
        add("ADDS",   K_DPR, 4'hE, 2'b00, 6'b001001, 4'd3,  4'b0110, 2'b00, 5'b00001, 5'b01000, 5'b0, 4'b0110);
        add("SUBSNE", K_DPR, 4'h1, 2'b00, 6'b000101, 4'd3,  4'b1001, 2'b01, 5'b00001, 5'b00000, 5'b0, 4'b0110);
        add("NV",     K_DPR, 4'hF, 2'b00, 6'b001000, 4'd3,  4'b0000, 2'b00, 5'b00001, 5'b00000, 5'b0, 4'b0110);
        add("HI",     K_DPR, 4'h8, 2'b00, 6'b001000, 4'd15, 4'b0000, 2'b00, 5'b00001, 5'b00000, 5'b0, 4'b0110);
        add("LSPC",   K_DPR, 4'h9, 2'b00, 6'b001000, 4'd15, 4'b0000, 2'b00, 5'b01001, 5'b01000, 5'b0, 4'b0110);

        Reset = 1'b1;
        bus.Cond = 4'hE; bus.Op = 2'b00; bus.Funct = 6'b0;
        bus.Rd = 4'd0; bus.ALUFlags = 4'b0;
        fv = vecs[0];
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset fetch", act_word(), exp_word(fv, 0));
        chk("reset flags", {12'h0, dut.flags}, 16'h0);
        Reset = 1'b0;

        foreach (vecs[k]) run_vec(vecs[k]);

        // reset while in MEMRD: back to FETCH, flags cleared, no writeback
        ldr = vecs[1];
        apply(ldr);
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                cyc(ldr, i);
            end else begin
                #1;
                chk("rst MEMRD", act_word(), exp_word(ldr, 3));
                Reset = 1'b1;
                #1;
                chk("rst held", act_word(), exp_word(ldr, 0));
                @(negedge CLK);
                Reset = 1'b0;
            end
        end
        #1;
        chk("rst fetch", act_word(), exp_word(ldr, 0));
        chk("rst flags", {12'h0, dut.flags}, 16'h0);
        @(negedge CLK);
        cyc(ldr, 1);
        cyc(ldr, 2);
        cyc(ldr, 3);
        cyc(ldr, 4);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
